// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage datapath.
//
// Sequences the IF/ID and ID/EX pipeline registers: detects load-use hazards
// between ID/EX and IF/ID, flushes IF/ID on a taken branch and freezes the
// back half of the pipe while data memory is busy. A memory wait that lasts
// TIMEOUT consecutive cycles parks the controller in a sticky error state
// that only reset leaves.
//
// Parameters:
//   CNT_W    width of the saturating stall statistics counter
//   TIMEOUT  max consecutive memBusy cycles before error (legal 2..255)
//
// Optional feature macro: HZ_STATS_EN
//   defined   -> stallCount counts cycles with pcWrite=0 (saturating)
//   undefined -> stallCount is tied to zero, no counter flops
//
// Ports:
//   clkHU, rstHU       clock (rising edge), synchronous active-high reset
//   idexMemRead        ID/EX holds a load
//   idexRt             destination register of the ID/EX instruction
//   ifidRs, ifidRt     source fields of the IF/ID instruction
//   ifidUsesRt         IF/ID instruction reads rt
//   branchTaken        taken branch resolved in EX/MEM
//   memBusy            data memory not ready this cycle
//   pcWrite            PC load enable
//   ifidWrite          IF/ID load enable
//   ifidFlush          IF/ID loads a NOP
//   idexBubble         ID/EX loads zero control fields
//   pipeHold           freeze ID/EX, EX/MEM, MEM/WB
//   hzErr              sticky memory timeout error
//   hzState            current FSM state (RUN/LUSTALL/WAIT/ERR)
//   stallCount         cycles with pcWrite=0

module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clkHU,
    input  logic             rstHU,
    input  logic             idexMemRead,
    input  logic [4:0]       idexRt,
    input  logic [4:0]       ifidRs,
    input  logic [4:0]       ifidRt,
    input  logic             ifidUsesRt,
    input  logic             branchTaken,
    input  logic             memBusy,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             pipeHold,
    output logic             hzErr,
    output logic [1:0]       hzState,
    output logic [CNT_W-1:0] stallCount
);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_LUSTALL = 2'b01;
    localparam logic [1:0] ST_WAIT    = 2'b10;
    localparam logic [1:0] ST_ERR     = 2'b11;

    // Wait counter value seen on the last tolerated busy cycle; the counter
    // is loaded with 1 on the first busy cycle, so this is TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic       hzErr_q, hzErr_d;
    logic       loadUse;
    logic       runEval;

    // r0 never carries a real dependency, so a load into r0 never stalls.
    assign loadUse = idexMemRead && (idexRt != 5'd0) &&
                     ((idexRt == ifidRs) || (ifidUsesRt && (idexRt == ifidRt)));

    // Mealy output and next-state logic. RUN, LUSTALL and a WAIT release
    // cycle share one priority list (memBusy > branchTaken > load-use).
    // memBusy wins over a branch because EX/MEM is frozen, so the branch is
    // still pending and gets taken on the release cycle.
    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        pipeHold   = 1'b0;
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        hzErr_d    = hzErr_q;
        runEval    = 1'b0;

        if (rstHU) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end else begin
            case (state_q)
                ST_ERR: begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    pipeHold  = 1'b1;
                end
                ST_WAIT: begin
                    if (memBusy) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        pipeHold  = 1'b1;
                        if (waitCnt_q == WAIT_LAST) begin
                            state_d = ST_ERR;
                            hzErr_d = 1'b1;
                        end else begin
                            waitCnt_d = waitCnt_q + 8'd1;
                        end
                    end else begin
                        runEval = 1'b1;
                    end
                end
                default: runEval = 1'b1;
            endcase

            if (runEval) begin
                if (memBusy) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    pipeHold  = 1'b1;
                    state_d   = ST_WAIT;
                    waitCnt_d = 8'd1;
                end else begin
                    waitCnt_d = 8'd0;
                    if (branchTaken) begin
                        // The IF/ID instruction is flushed, so any load-use
                        // against it is irrelevant.
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                        state_d    = ST_RUN;
                    end else if (loadUse) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexBubble = 1'b1;
                        state_d    = ST_LUSTALL;
                    end else begin
                        state_d    = ST_RUN;
                    end
                end
            end
        end
    end

    always_ff @(posedge clkHU) begin
        if (rstHU) begin
            state_q   <= ST_RUN;
            waitCnt_q <= 8'd0;
            hzErr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            hzErr_q   <= hzErr_d;
        end
    end

    assign hzState = state_q;
    assign hzErr   = hzErr_q;

`ifdef HZ_STATS_EN
    logic [CNT_W-1:0] stallCnt_q;

    // Saturating count of frozen-PC cycles; reset cycles are not counted.
    always_ff @(posedge clkHU) begin
        if (rstHU) begin
            stallCnt_q <= '0;
        end else if (!pcWrite && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_q <= stallCnt_q + CNT_W'(1);
        end
    end

    assign stallCount = stallCnt_q;
`else
    assign stallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

`ifdef HZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int CNT_W    = 16;
    localparam int TO_MAIN  = 64;
    localparam int TO_SHORT = 4;

    logic       clkHU = 1'b0;
    logic       rstHU;
    logic       idexMemRead;
    logic [4:0] idexRt, ifidRs, ifidRt;
    logic       ifidUsesRt, branchTaken, memBusy;

    logic             pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold, hzErr;
    logic [1:0]       hzState;
    logic [CNT_W-1:0] stallCount;

    logic             toPcWrite, toIfidWrite, toIfidFlush, toIdexBubble, toPipeHold, toHzErr;
    logic [1:0]       toHzState;
    logic [CNT_W-1:0] toStallCount;

    always #5 clkHU = ~clkHU;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO_MAIN)) dutMain (
        .clkHU(clkHU), .rstHU(rstHU), .idexMemRead(idexMemRead), .idexRt(idexRt),
        .ifidRs(ifidRs), .ifidRt(ifidRt), .ifidUsesRt(ifidUsesRt),
        .branchTaken(branchTaken), .memBusy(memBusy),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .idexBubble(idexBubble), .pipeHold(pipeHold), .hzErr(hzErr),
        .hzState(hzState), .stallCount(stallCount)
    );

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TO_SHORT)) dutTo (
        .clkHU(clkHU), .rstHU(rstHU), .idexMemRead(idexMemRead), .idexRt(idexRt),
        .ifidRs(ifidRs), .ifidRt(ifidRt), .ifidUsesRt(ifidUsesRt),
        .branchTaken(branchTaken), .memBusy(memBusy),
        .pcWrite(toPcWrite), .ifidWrite(toIfidWrite), .ifidFlush(toIfidFlush),
        .idexBubble(toIdexBubble), .pipeHold(toPipeHold), .hzErr(toHzErr),
        .hzState(toHzState), .stallCount(toStallCount)
    );

    typedef struct packed {
        logic [1:0]  state;
        logic [7:0]  waitCnt;
        logic        err;
        logic [15:0] cnt;
    } modelT;

    typedef struct packed {
        logic        pc, ifw, flush, bubble, hold, err;
        logic [1:0]  state;
        logic [15:0] cnt;
    } expT;

    expT   expQ[$];
    modelT mMain, mTo;
    int    errors = 0;
    int    checks = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Behavioural reference: current-cycle outputs and next model state.
    function automatic void modelStep(input modelT m, input logic rst, input logic lu,
                                      input logic br, input logic busy, input int timeout,
                                      output expT e, output modelT n);
        e = '{pc: 1'b1, ifw: 1'b1, flush: 1'b0, bubble: 1'b0, hold: 1'b0,
              err: m.err, state: m.state, cnt: (STATS ? m.cnt : 16'd0)};
        n = m;
        if (rst) begin
            e.pc = 1'b0; e.ifw = 1'b0; e.flush = 1'b1; e.bubble = 1'b1;
            n = '0;
            return;
        end
        if (m.state == 2'b11) begin
            e.pc = 1'b0; e.ifw = 1'b0; e.hold = 1'b1;
        end else if (m.state == 2'b10 && busy) begin
            e.pc = 1'b0; e.ifw = 1'b0; e.hold = 1'b1;
            if (int'(m.waitCnt) == timeout - 1) begin
                n.state = 2'b11;
                n.err   = 1'b1;
            end else begin
                n.waitCnt = m.waitCnt + 8'd1;
            end
        end else if (busy) begin
            e.pc = 1'b0; e.ifw = 1'b0; e.hold = 1'b1;
            n.state = 2'b10; n.waitCnt = 8'd1;
        end else begin
            n.waitCnt = 8'd0;
            if (br) begin
                e.flush = 1'b1; e.bubble = 1'b1; n.state = 2'b00;
            end else if (lu) begin
                e.pc = 1'b0; e.ifw = 1'b0; e.bubble = 1'b1; n.state = 2'b01;
            end else begin
                n.state = 2'b00;
            end
        end
        if (!e.pc && m.cnt != 16'hFFFF) n.cnt = m.cnt + 16'd1;
    endfunction

    task automatic popAndCompare(input string who, input logic pc, input logic ifw,
                                 input logic fl, input logic bu, input logic ho,
                                 input logic er, input logic [1:0] st,
                                 input logic [CNT_W-1:0] ct);
        expT e;
        checkOutput({who, ".queueNonEmpty"}, 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() == 0) return;
        e = expQ.pop_front();
        checkOutput({who, ".pcWrite"},    32'(pc), 32'(e.pc));
        checkOutput({who, ".ifidWrite"},  32'(ifw), 32'(e.ifw));
        checkOutput({who, ".ifidFlush"},  32'(fl), 32'(e.flush));
        checkOutput({who, ".idexBubble"}, 32'(bu), 32'(e.bubble));
        checkOutput({who, ".pipeHold"},   32'(ho), 32'(e.hold));
        checkOutput({who, ".hzErr"},      32'(er), 32'(e.err));
        checkOutput({who, ".hzState"},    32'(st), 32'(e.state));
        checkOutput({who, ".stallCount"}, 32'(ct), 32'(e.cnt));
    endtask

    // One clock cycle: drive at the falling edge, queue the expected results
    // for both instances, compare shortly before the rising edge.
    task automatic applyStimulus(input logic rst, input logic memRead, input logic [4:0] exRt,
                                 input logic [4:0] idRs, input logic [4:0] idRt,
                                 input logic usesRt, input logic br, input logic busy);
        expT   eM, eT;
        modelT nM, nT;
        logic  lu;
        @(negedge clkHU);
        rstHU = rst; idexMemRead = memRead; idexRt = exRt; ifidRs = idRs;
        ifidRt = idRt; ifidUsesRt = usesRt; branchTaken = br; memBusy = busy;
        lu = memRead && (exRt != 5'd0) && ((exRt == idRs) || (usesRt && exRt == idRt));
        modelStep(mMain, rst, lu, br, busy, TO_MAIN, eM, nM);
        modelStep(mTo, rst, lu, br, busy, TO_SHORT, eT, nT);
        expQ.push_back(eM);
        expQ.push_back(eT);
        #2;
        popAndCompare("main", pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold,
                      hzErr, hzState, stallCount);
        popAndCompare("to", toPcWrite, toIfidWrite, toIfidFlush, toIdexBubble, toPipeHold,
                      toHzErr, toHzState, toStallCount);
        mMain = nM;
        mTo   = nT;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rstHU = 1'b1; idexMemRead = 1'b0; idexRt = '0; ifidRs = '0; ifidRt = '0;
        ifidUsesRt = 1'b0; branchTaken = 1'b0; memBusy = 1'b0;
        mMain = '0; mTo = '0;
        @(posedge clkHU);

        // Reset held two cycles, then release
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 8, 8, 0, 0, 1, 1);
        checkOutput("reset.stallCount", 32'(stallCount), 32'd0);
        checkOutput("reset.hzState", 32'(hzState), 32'd0);
        idle(1);
        checkOutput("release.pcWrite", 32'(pcWrite), 32'd1);

        // Load-use on rs, then the bubble sits in ID/EX
        applyStimulus(0, 1, 8, 8, 0, 0, 0, 0);
        checkOutput("lu.idexBubble", 32'(idexBubble), 32'd1);
        applyStimulus(0, 0, 8, 8, 0, 0, 0, 0);
        checkOutput("lu.hzState", 32'(hzState), 32'd1);
        checkOutput("lu.stallCount", 32'(stallCount), STATS ? 32'd1 : 32'd0);
        idle(1);
        // Load into r0 never stalls
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("luR0.pcWrite", 32'(pcWrite), 32'd1);

        // rt hazard only when the instruction reads rt
        applyStimulus(0, 1, 9, 3, 9, 0, 0, 0);
        applyStimulus(0, 1, 9, 3, 9, 1, 0, 0);
        applyStimulus(0, 0, 9, 3, 9, 1, 0, 0);
        // Back-to-back load-use is honoured from LUSTALL
        applyStimulus(0, 1, 5, 5, 0, 0, 0, 0);
        applyStimulus(0, 1, 5, 5, 0, 0, 0, 0);
        idle(1);

        // Branch beats load-use in the same cycle
        applyStimulus(0, 1, 8, 8, 0, 0, 1, 0);
        checkOutput("brLu.pcWrite", 32'(pcWrite), 32'd1);
        idle(1);

        // Memory wait 5 cycles with a pending branch; short instance times out
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("waitRel.ifidFlush", 32'(ifidFlush), 32'd1);
        checkOutput("waitTo.hzState", 32'(toHzState), 32'd3);
        idle(1);
        // Release with a load-use goes to LUSTALL
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 7, 7, 0, 0, 0, 0);
        idle(1);

        // Timeout on the short instance, sticky until reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 4, 4, 0, 0, 1, 0);
        checkOutput("timeout.hzErr", 32'(toHzErr), 32'd1);
        checkOutput("timeout.hzState", 32'(toHzState), 32'd3);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        checkOutput("errReset.hzErr", 32'(toHzErr), 32'd0);

        // Full-length timeout on the main instance
        for (int i = 0; i < TO_MAIN + 2; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("mainTimeout.hzState", 32'(hzState), 32'd3);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic over a small register range to provoke matches
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
